// File: rtl/toy_fp_issue_queue_pkg.sv
// Shared types for the FP issue queue: EU op payload and queue sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package toy_fp_issue_queue_pkg;

  // Number of pipeline stages inside the FP execution unit.
  localparam int FP_STAGES   = 3;
  // Issue queue depth used by the core top level.
  localparam int FP_IQ_DEPTH = 4;

  typedef enum logic [1:0] {
    EU_OP_ADD = 2'd0,
    EU_OP_SUB = 2'd1,
    EU_OP_MUL = 2'd2,
    EU_OP_CMP = 2'd3
  } eu_op_e;

  // Op payload handed from FP dispatch to the FP execution unit.
  typedef struct packed {
    eu_op_e      op;
    logic [4:0]  rd;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
  } eu_pkg;

endpackage

// File: rtl/toy_fp_issue_queue_if.sv
// Valid/ready op channel carrying one eu_pkg payload.
// Latency: none (wires only).
// Backpressure: master holds vld/pld until rdy is seen high.
interface toy_fp_issue_queue_if;
  import toy_fp_issue_queue_pkg::*;

  logic  vld;
  logic  rdy;
  eu_pkg pld;

  modport master (output vld, output pld, input rdy);
  modport slave  (input vld, input pld, output rdy);

endinterface

// File: rtl/toy_fp_issue_queue_wrap_ptr.sv
// Circular pointer for a DEPTH-entry flop array, wrapping at DEPTH-1 by compare.
// Latency: pointer updates one clock after inc/clr.
// Backpressure: none; clear has priority over increment.
module toy_wrap_ptr #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Advance by one, wrapping explicitly so non power-of-two depths work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/toy_fp_issue_queue.sv
// In-order op FIFO between FP dispatch and the FP EU; flush drops all entries.
// Latency: 1 cycle push-to-head; 0 cycles on an empty queue when TOY_FP_IQ_BYPASS_EN is defined.
// Backpressure: in_rdy = !full only (no pop-through), so no rdy-to-rdy combinational path.
module toy_fp_issue_queue
  import toy_fp_issue_queue_pkg::*;
#(
  parameter  int DEPTH = FP_IQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  toy_fp_issue_queue_if.slave   i_disp,
  toy_fp_issue_queue_if.master  o_eu,
  output logic [CNT_W-1:0]      o_iq_cnt,
  output logic                  o_iq_full,
  output logic                  o_iq_empty
);

  eu_pkg            r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_wr_en;
  logic             w_rd_inc;

  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Ready looks only at occupancy; a flush cycle still reports !full.
  assign i_disp.rdy = !w_full;
  assign w_push     = i_disp.vld & !w_full;

`ifdef TOY_FP_IQ_BYPASS_EN
  // Empty queue forwards the incoming op straight to the EU; it is never stored.
  assign w_bypass = w_empty & i_disp.vld & o_eu.rdy & !i_flush;
  assign o_eu.vld = !w_empty | i_disp.vld;
  assign o_eu.pld = w_empty ? i_disp.pld : r_mem[w_rd_ptr];
`else
  assign w_bypass = 1'b0;
  assign o_eu.vld = !w_empty;
  assign o_eu.pld = r_mem[w_rd_ptr];
`endif

  // A stored entry leaves only when one exists; bypassed ops never touch storage.
  assign w_pop    = !w_empty & o_eu.rdy;
  assign w_wr_en  = w_push & !w_bypass & !i_flush;
  assign w_rd_inc = w_pop & !i_flush;

  toy_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr_en),
    .i_clr (i_flush),
    .o_ptr (w_wr_ptr)
  );

  toy_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_inc),
    .i_clr (i_flush),
    .o_ptr (w_rd_ptr)
  );

  // Occupancy: flush clears, push-only counts up, pop-only counts down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (w_wr_en && !w_pop) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_wr_en && w_pop) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Payload storage is not reset; contents only matter while counted.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[w_wr_ptr] <= i_disp.pld;
    end
  end

  assign o_iq_cnt   = r_cnt;
  assign o_iq_full  = w_full;
  assign o_iq_empty = w_empty;

endmodule

// File: tb/tb_toy_fp_issue_queue.sv
// Directed bench for toy_fp_issue_queue at DEPTH=4 and DEPTH=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_toy_fp_issue_queue;
  import toy_fp_issue_queue_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush4;
  logic       flush3;
  logic [2:0] cnt4;
  logic       full4;
  logic       empty4;
  logic [1:0] cnt3;
  logic       full3;
  logic       empty3;

  int n_checks;
  int n_fail;

  toy_fp_issue_queue_if in4();
  toy_fp_issue_queue_if out4();
  toy_fp_issue_queue_if in3();
  toy_fp_issue_queue_if out3();

  toy_fp_issue_queue #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush4),
    .i_disp(in4), .o_eu(out4),
    .o_iq_cnt(cnt4), .o_iq_full(full4), .o_iq_empty(empty4)
  );

  toy_fp_issue_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush3),
    .i_disp(in3), .o_eu(out3),
    .o_iq_cnt(cnt3), .o_iq_full(full3), .o_iq_empty(empty3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic eu_pkg mk(input int tag);
    eu_pkg p;
    p.op      = eu_op_e'(tag[1:0]);
    p.rd      = 5'(tag);
    p.rs1_dat = 32'hA000_0000 + 32'(tag);
    p.rs2_dat = 32'h5000_0000 ^ 32'(tag);
    return p;
  endfunction

  task automatic test_reset();
    logic exp_vld;
`ifdef TOY_FP_IQ_BYPASS_EN
    exp_vld = 1'b1;
`else
    exp_vld = 1'b0;
`endif
    rst_n = 1'b0; flush4 = 1'b0; flush3 = 1'b0;
    in4.vld = 1'b1; in4.pld = mk(99); out4.rdy = 1'b0;
    in3.vld = 1'b1; in3.pld = mk(98); out3.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt4: got %0d exp 0", cnt4); end
      n_checks++; if (in4.rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b exp 1", in4.rdy); end
      n_checks++; if (out4.vld !== exp_vld) begin n_fail++; $display("FAIL reset_out_vld: got %b exp %b", out4.vld, exp_vld); end
      n_checks++; if (cnt3 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt3: got %0d exp 0", cnt3); end
    end
    rst_n = 1'b1; in4.vld = 1'b0; in3.vld = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL post_reset_cnt: got %0d exp 0", cnt4); end
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_vld: got %b exp 0", out4.vld); end
    n_checks++; if (in4.rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_rdy: got %b exp 1", in4.rdy); end
    n_checks++; if (empty4 !== 1'b1 || full4 !== 1'b0) begin n_fail++; $display("FAIL post_reset_flags: empty %b full %b exp 1 0", empty4, full4); end
  endtask

  task automatic test_fill_drain();
    out4.rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in4.vld = 1'b1; in4.pld = mk(1 + i); #1;
      n_checks++; if (cnt4 !== 3'(i)) begin n_fail++; $display("FAIL fill_cnt: got %0d exp %0d", cnt4, i); end
    end
    @(negedge clk);
    in4.vld = 1'b1; in4.pld = mk(5); #1;
    n_checks++; if (cnt4 !== 3'd4) begin n_fail++; $display("FAIL full_cnt: got %0d exp 4", cnt4); end
    n_checks++; if (full4 !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b exp 1", full4); end
    n_checks++; if (in4.rdy !== 1'b0) begin n_fail++; $display("FAIL full_in_rdy: got %b exp 0", in4.rdy); end
    @(negedge clk);
    in4.vld = 1'b0; out4.rdy = 1'b1; #1;
    n_checks++; if (cnt4 !== 3'd4) begin n_fail++; $display("FAIL refused_push_cnt: got %0d exp 4", cnt4); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_checks++; if (out4.vld !== 1'b1) begin n_fail++; $display("FAIL drain_vld[%0d]: got %b exp 1", i, out4.vld); end
      n_checks++; if (out4.pld !== mk(1 + i)) begin n_fail++; $display("FAIL drain_pld[%0d]: got %h exp %h", i, out4.pld, mk(1 + i)); end
    end
    @(negedge clk);
    out4.rdy = 1'b0; #1;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b exp 1", empty4); end
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL drain_out_vld: got %b exp 0", out4.vld); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    in4.vld = 1'b1; in4.pld = mk(10); out4.rdy = 1'b1; #1;
`ifdef TOY_FP_IQ_BYPASS_EN
    n_checks++; if (out4.vld !== 1'b1) begin n_fail++; $display("FAIL bypass_vld: got %b exp 1", out4.vld); end
    n_checks++; if (out4.pld !== mk(10)) begin n_fail++; $display("FAIL bypass_pld: got %h exp %h", out4.pld, mk(10)); end
    @(negedge clk);
    in4.vld = 1'b0; out4.rdy = 1'b0; #1;
    n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL bypass_cnt: got %0d exp 0", cnt4); end
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL bypass_after_vld: got %b exp 0", out4.vld); end
`else
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL latency_same_cycle_vld: got %b exp 0", out4.vld); end
    @(negedge clk);
    in4.vld = 1'b0; out4.rdy = 1'b0; #1;
    n_checks++; if (out4.vld !== 1'b1) begin n_fail++; $display("FAIL latency_next_vld: got %b exp 1", out4.vld); end
    n_checks++; if (out4.pld !== mk(10)) begin n_fail++; $display("FAIL latency_next_pld: got %h exp %h", out4.pld, mk(10)); end
    n_checks++; if (cnt4 !== 3'd1) begin n_fail++; $display("FAIL latency_cnt: got %0d exp 1", cnt4); end
    out4.rdy = 1'b1;
    @(negedge clk);
    out4.rdy = 1'b0; #1;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL latency_empty: got %b exp 1", empty4); end
`endif
  endtask

  task automatic test_wrap();
    eu_pkg q[$];
    eu_pkg e;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 7; c++) begin
      @(negedge clk);
      in3.vld = (sent < 7); in3.pld = mk(20 + sent); out3.rdy = ((c % 3) != 1); #1;
      n_checks++; if (cnt3 !== 2'(q.size())) begin n_fail++; $display("FAIL wrap_cnt: got %0d exp %0d", cnt3, q.size()); end
      if (in3.vld && in3.rdy) begin q.push_back(in3.pld); sent++; end
      if (out3.vld && out3.rdy) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL wrap_spurious_pop: got %h exp none", out3.pld);
        end else begin
          e = q.pop_front();
          if (out3.pld !== e) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h exp %h", got, out3.pld, e); end
        end
        got++;
      end
    end
    @(negedge clk);
    in3.vld = 1'b0; out3.rdy = 1'b0;
    n_checks++; if (got != 7) begin n_fail++; $display("FAIL wrap_count: got %0d exp 7", got); end
  endtask

  task automatic test_simul();
    out4.rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in4.vld = 1'b1; in4.pld = mk(30 + i);
    end
    @(negedge clk);
    in4.vld = 1'b1; in4.pld = mk(32); out4.rdy = 1'b1; #1;
    n_checks++; if (cnt4 !== 3'd2) begin n_fail++; $display("FAIL simul_pre_cnt: got %0d exp 2", cnt4); end
    n_checks++; if (out4.pld !== mk(30)) begin n_fail++; $display("FAIL simul_pre_head: got %h exp %h", out4.pld, mk(30)); end
    @(negedge clk);
    in4.vld = 1'b0; out4.rdy = 1'b0; #1;
    n_checks++; if (cnt4 !== 3'd2) begin n_fail++; $display("FAIL simul_cnt: got %0d exp 2", cnt4); end
    n_checks++; if (out4.pld !== mk(31)) begin n_fail++; $display("FAIL simul_head: got %h exp %h", out4.pld, mk(31)); end
    out4.rdy = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (out4.pld !== mk(32)) begin n_fail++; $display("FAIL simul_tail: got %h exp %h", out4.pld, mk(32)); end
    n_checks++; if (cnt4 !== 3'd1) begin n_fail++; $display("FAIL simul_tail_cnt: got %0d exp 1", cnt4); end
    @(negedge clk);
    out4.rdy = 1'b0; #1;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL simul_empty: got %b exp 1", empty4); end
  endtask

  task automatic test_flush();
    out4.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in4.vld = 1'b1; in4.pld = mk(40 + i);
    end
    @(negedge clk);
    flush4 = 1'b1; in4.vld = 1'b1; in4.pld = mk(43); out4.rdy = 1'b1; #1;
    n_checks++; if (cnt4 !== 3'd3) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d exp 3", cnt4); end
    n_checks++; if (in4.rdy !== 1'b1) begin n_fail++; $display("FAIL flush_in_rdy: got %b exp 1", in4.rdy); end
    @(negedge clk);
    flush4 = 1'b0; in4.vld = 1'b0; out4.rdy = 1'b0; #1;
    n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d exp 0", cnt4); end
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL flush_out_vld: got %b exp 0", out4.vld); end
    in4.vld = 1'b1; in4.pld = mk(44);
    @(negedge clk);
    in4.vld = 1'b0; #1;
    n_checks++; if (cnt4 !== 3'd1) begin n_fail++; $display("FAIL flush_next_cnt: got %0d exp 1", cnt4); end
    n_checks++; if (out4.pld !== mk(44)) begin n_fail++; $display("FAIL flush_next_head: got %h exp %h", out4.pld, mk(44)); end
    out4.rdy = 1'b1;
    @(negedge clk);
    out4.rdy = 1'b0; #1;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL flush_final_empty: got %b exp 1", empty4); end
  endtask

  task automatic test_backpressure();
    eu_pkg q[$];
    eu_pkg e;
    int sent = 0;
    int got = 0;
    bit dropped = 1'b0;
    for (int c = 0; c < 300 && got < 16; c++) begin
      @(negedge clk);
      in4.vld = (sent < 16); in4.pld = mk(50 + sent);
      out4.rdy = ((c % (FP_STAGES + 1)) == FP_STAGES); #1;
      n_checks++; if (cnt4 !== 3'(q.size())) begin n_fail++; $display("FAIL bp_cnt: got %0d exp %0d", cnt4, q.size()); end
      n_checks++; if (in4.rdy !== (q.size() < 4)) begin n_fail++; $display("FAIL bp_in_rdy: got %b exp %b", in4.rdy, (q.size() < 4)); end
      if (!in4.rdy) dropped = 1'b1;
      if (in4.vld && in4.rdy) begin q.push_back(in4.pld); sent++; end
      if (out4.vld && out4.rdy) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious_pop: got %h exp none", out4.pld);
        end else begin
          e = q.pop_front();
          if (out4.pld !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", got, out4.pld, e); end
        end
        got++;
      end
    end
    @(negedge clk);
    in4.vld = 1'b0; out4.rdy = 1'b0;
    n_checks++; if (got != 16) begin n_fail++; $display("FAIL bp_count: got %0d exp 16", got); end
    n_checks++; if (dropped != 1'b1) begin n_fail++; $display("FAIL bp_rdy_drop: got %b exp 1", dropped); end
  endtask

  task automatic test_mid_reset();
    out4.rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in4.vld = 1'b1; in4.pld = mk(70 + i);
    end
    @(negedge clk);
    rst_n = 1'b0; in4.vld = 1'b1; in4.pld = mk(72); out4.rdy = 1'b1; #1;
    n_checks++; if (cnt4 !== 3'd2) begin n_fail++; $display("FAIL mid_reset_pre_cnt: got %0d exp 2", cnt4); end
    @(negedge clk);
    rst_n = 1'b1; in4.vld = 1'b0; out4.rdy = 1'b0; #1;
    n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d exp 0", cnt4); end
    n_checks++; if (out4.vld !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_vld: got %b exp 0", out4.vld); end
    n_checks++; if (in4.rdy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_rdy: got %b exp 1", in4.rdy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_wrap();
    test_simul();
    test_flush();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
